// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, 8 data bits LSB first, parity bit, stop bit.
// A one-byte holding register lets the next byte be queued while a frame is on
// the line, so consecutive frames go out back to back with no idle gap.
module uart_tx #(
    parameter int unsigned BIT_TICKS  = 20,    // clk_br cycles per serial bit, 2..255
    parameter bit          PARITY_ODD = 1'b0   // 0 = even parity, 1 = odd parity
) (
    input  logic       clk_br,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       load,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(BIT_TICKS - 1);

    state_t     state_q, state_d;
    logic [7:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic       done_q, done_d;
    logic       tx_q, tx_d;

    logic       accept;
    logic       bit_end;

    // A load is only taken while the holding register is empty.
    assign accept  = load && !hold_valid_q;
    // Last cycle of the current bit period.
    assign bit_end = (tick_q == TICK_LAST);

    function automatic logic calc_par(input logic [7:0] b);
        return (^b) ^ PARITY_ODD;
    endfunction

    // State register and datapath registers; reset drops the line high at once.
    always_ff @(posedge clk_br or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            done_q       <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            done_q       <= done_d;
            tx_q         <= tx_d;
        end
    end

    // Next-state, bit timing, holding-register control and the next line level.
    always_comb begin
        state_d      = state_q;
        tick_d       = bit_end ? 8'd0 : tick_q + 8'd1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_d        = par_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                tick_d = 8'd0;
                bit_d  = 3'd0;
                if (accept) begin
                    shift_d = data_in;
                    par_d   = calc_par(data_in);
                    state_d = START;
                end
            end

            START: begin
                if (accept) begin
                    hold_d       = data_in;
                    hold_valid_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end

            DATA: begin
                if (accept) begin
                    hold_d       = data_in;
                    hold_valid_d = 1'b1;
                end
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end

            PARITY: begin
                if (accept) begin
                    hold_d       = data_in;
                    hold_valid_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end

            STOP: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    bit_d  = 3'd0;
                    if (hold_valid_q) begin
                        // Queued byte starts immediately, no idle bit between frames.
                        shift_d      = hold_q;
                        par_d        = calc_par(hold_q);
                        hold_valid_d = 1'b0;
                        state_d      = START;
                    end else if (accept) begin
                        // Load coinciding with frame end bypasses the holding register.
                        shift_d = data_in;
                        par_d   = calc_par(data_in);
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    hold_d       = data_in;
                    hold_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                tick_d  = 8'd0;
                bit_d   = 3'd0;
            end
        endcase

        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign ready = !hold_valid_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed loads; a monitor decodes frames off the line and
// checks them, and the done pulses, against queued expectations.
module tb_uart_tx;

    localparam int BT  = 20;
    localparam int BT2 = 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       load    = 1'b0;
    logic       load2   = 1'b0;
    logic       ready, busy, done, tx;
    logic       ready2, busy2, done2, tx2;

    uart_tx dut (
        .clk_br  (clk),
        .rst     (rst),
        .data_in (data_in),
        .load    (load),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .tx      (tx)
    );

    uart_tx #(.BIT_TICKS(BT2), .PARITY_ODD(1'b1)) dut2 (
        .clk_br  (clk),
        .rst     (rst),
        .data_in (data_in),
        .load    (load2),
        .ready   (ready2),
        .busy    (busy2),
        .done    (done2),
        .tx      (tx2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         start;
    } frame_t;

    frame_t exp_q[$];
    int     done_exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                      name, act, act, req, req, cyc);
    endtask

    // Must be called at a falling edge; returns at the falling edge where cyc == n.
    task automatic wait_cyc(input int n);
        if (cyc > n) chk("schedule", cyc, n);
        while (cyc < n) @(negedge clk);
    endtask

    // Presents a byte so that the rising edge numbered edge_no accepts it.
    task automatic load_at(input int edge_no, input logic [7:0] d, input bit second);
        wait_cyc(edge_no - 1);
        data_in = d;
        if (second) load2 = 1'b1;
        else        load  = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        load2   = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic p, input int start);
        frame_t f;
        f.data  = d;
        f.par   = p;
        f.start = start;
        exp_q.push_back(f);
        done_exp_q.push_back(start + 11 * BT);
    endtask

    // Monitor: decodes frames by mid-bit sampling and checks done pulse timing.
    initial begin : monitor
        logic [10:0] fb;
        logic [7:0]  rx;
        int          fstart;
        int          off;
        bit          in_frame;
        frame_t      e;
        fb       = '0;
        rx       = '0;
        fstart   = 0;
        in_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_frame = 1'b0;
            end else begin
                if (done) begin
                    if (done_exp_q.size() == 0) chk("done_unexpected", cyc, -1);
                    else chk("done_cycle", cyc, done_exp_q.pop_front());
                end
                if (!in_frame && tx == 1'b0) begin
                    in_frame = 1'b1;
                    fstart   = cyc;
                end
                if (in_frame) begin
                    off = cyc - fstart;
                    if (off % BT == BT / 2) begin
                        fb[off / BT] = tx;
                        if (off / BT == 10) begin
                            in_frame = 1'b0;
                            for (int i = 0; i < 8; i++) rx[i] = fb[i + 1];
                            if (exp_q.size() == 0) begin
                                chk("frame_unexpected", fstart, -1);
                            end else begin
                                e = exp_q.pop_front();
                                $display("frame at cycle %0d: data 0x%02h parity %0d (expected 0x%02h/%0d at %0d)",
                                         fstart, rx, fb[9], e.data, e.par, e.start);
                                chk("frame_start_cycle", fstart, e.start);
                                chk("frame_start_bit", int'(fb[0]), 0);
                                chk("frame_data", int'(rx), int'(e.data));
                                chk("frame_parity", int'(fb[9]), int'(e.par));
                                chk("frame_stop_bit", int'(fb[10]), 1);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    int a, b, c, d, e, f, bad;
    logic [10:0] exp2;

    initial begin : stimulus
        // Reset state, asynchronous
        #1 rst = 1'b0;
        #1;
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ready", int'(ready), 1);
        chk("reset_done", int'(done), 0);
        chk("reset_tx2", int'(tx2), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Single frame 0x55, even parity 0
        a = cyc + 5;
        expect_frame(8'h55, 1'b0, a);
        load_at(a, 8'h55, 1'b0);
        wait_cyc(a + 1);
        chk("single_busy", int'(busy), 1);
        chk("single_ready", int'(ready), 1);
        chk("single_tx_start", int'(tx), 0);
        wait_cyc(a + 221);
        chk("single_busy_end", int'(busy), 0);
        chk("single_ready_end", int'(ready), 1);

        // Back to back 0xA5 then 0x0F; overrun 0xFF ignored
        b = a + 240;
        expect_frame(8'hA5, 1'b0, b);
        expect_frame(8'h0F, 1'b0, b + 220);
        load_at(b, 8'hA5, 1'b0);
        load_at(b + 5, 8'h0F, 1'b0);
        chk("b2b_ready_held", int'(ready), 0);
        load_at(b + 50, 8'hFF, 1'b0);
        chk("overrun_ready", int'(ready), 0);
        wait_cyc(b + 219);
        chk("b2b_ready_219", int'(ready), 0);
        wait_cyc(b + 220);
        chk("b2b_ready_220", int'(ready), 1);
        chk("b2b_busy_220", int'(busy), 1);
        chk("b2b_tx_220", int'(tx), 0);
        wait_cyc(b + 441);
        chk("b2b_busy_end", int'(busy), 0);

        // Load on the same edge as the end of stop with holding empty
        c = b + 460;
        expect_frame(8'h07, 1'b1, c);
        expect_frame(8'h80, 1'b1, c + 220);
        load_at(c, 8'h07, 1'b0);
        load_at(c + 220, 8'h80, 1'b0);
        chk("direct_ready", int'(ready), 1);
        chk("direct_tx", int'(tx), 0);
        wait_cyc(c + 441);
        chk("direct_busy_end", int'(busy), 0);

        // Reset during data bit 3 with a byte held
        d = c + 460;
        expect_frame(8'h3C, 1'b0, d);
        load_at(d, 8'h3C, 1'b0);
        load_at(d + 10, 8'h99, 1'b0);
        chk("abort_ready_held", int'(ready), 0);
        wait_cyc(d + 90);
        #2;
        exp_q.delete();
        done_exp_q.delete();
        rst = 1'b0;
        #1;
        chk("abort_tx", int'(tx), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(ready), 1);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("idle_after_reset", bad, 0);

        // First load after reset is taken; the lost held byte never appears
        e = cyc + 5;
        expect_frame(8'h5A, 1'b0, e);
        load_at(e, 8'h5A, 1'b0);
        wait_cyc(e + 221);
        chk("post_reset_busy_end", int'(busy), 0);
        wait_cyc(e + 240);
        chk("held_byte_lost", int'(busy), 0);

        // Odd parity, 4 cycles per bit, data 0x00: parity 1, 44-cycle frame
        f = e + 250;
        exp2 = 11'b11_00000000_0;
        load_at(f, 8'h00, 1'b1);
        for (int k = 0; k < 11; k++) begin
            wait_cyc(f + BT2 * k + BT2 / 2);
            chk($sformatf("odd_bit%0d", k), int'(tx2), int'(exp2[k]));
        end
        wait_cyc(f + 43);
        chk("odd_done_43", int'(done2), 0);
        wait_cyc(f + 44);
        chk("odd_done_44", int'(done2), 1);
        wait_cyc(f + 45);
        chk("odd_done_45", int'(done2), 0);
        chk("odd_busy_45", int'(busy2), 0);

        wait_cyc(f + 60);
        chk("frames_outstanding", exp_q.size(), 0);
        chk("done_outstanding", done_exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: BIT_TICKS, 20, clk_br cycles per serial bit (legal range 2..255).
REQ-002 Parameter: PARITY_ODD, 0, parity sense (0 = even, 1 = odd).
REQ-003 Port: clk_br  input  1  bit-rate clock; all sequential logic on its rising edge; the block uses this single clock only.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: data_in  input  8  byte to transmit; sampled only on an accepted load.
REQ-006 Port: load  input  1  transmit request; accepted at a rising edge where load=1 and ready=1.
REQ-007 Port: ready  output  1  holding register empty; a new byte can be accepted.
REQ-008 Port: busy  output  1  a frame is on the line (FSM not IDLE).
REQ-009 Port: done  output  1  one-cycle pulse at frame completion.
REQ-010 Port: tx  output  1  serial line; idle level high.

Function
REQ-011 Frame format, in order: start bit (0), 8 data bits LSB first, parity bit, stop bit (1); 11 bits, 11*BIT_TICKS cycles per frame (220 at default).
REQ-012 Parity bit = XOR of the 8 data bits, XOR PARITY_ODD.
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP; encoded with 3 bits; unused encodings return to IDLE on the next edge.
REQ-014 Each bit state holds tx constant for exactly BIT_TICKS cycles, counted by a tick counter reset to 0 on every state or bit change.
REQ-015 IDLE: tx=1; on an accepted load with the holding register empty, capture data_in into the shift register and enter START at that same edge (tx=0 from that edge, latency 0).
REQ-016 START -> DATA after BIT_TICKS cycles; DATA shifts one bit per bit period, 3-bit bit counter 0..7; after bit 7 -> PARITY; after BIT_TICKS -> STOP.
REQ-017 Holding register: one byte plus valid flag; an accepted load in any state other than IDLE writes it and sets valid; ready = ~valid.
REQ-018 End of STOP with holding valid: move holding into the shift register, clear valid, enter START at the same edge; no idle cycle between frames.
REQ-019 End of STOP with holding empty: enter IDLE.
REQ-020 done=1 for exactly the one cycle following the edge that ends STOP, in both the back-to-back and the idle case.
REQ-021 A load with ready=0 is ignored; data_in is not sampled; the holding register is unchanged.
REQ-022 A load and the end of STOP on the same edge with holding empty: the new byte goes directly to the shift register; ready stays 1.
REQ-023 data_in changes after acceptance do not affect the frame in progress or the held byte.
REQ-024 busy=1 in every state except IDLE.

Reset
REQ-025 rst=0 asynchronously forces: state IDLE; tx=1; busy=0; ready=1; done=0; tick counter, bit counter, shift register, holding register and valid all cleared.
REQ-026 Reset asserted mid-frame aborts the frame immediately (tx high without waiting for a clock); no done pulse is generated.
REQ-027 After rst rises, the first edge with load=1 is accepted normally.

Verification
REQ-028 Reset check: rst=0 at any point -> tx=1, busy=0, ready=1, done=0 within the same timestep.
REQ-029 Single frame, default parameters, load with 0x55 in IDLE -> tx at 20-cycle intervals is 0,1,0,1,0,1,0,1,0,0(parity),1(stop); done pulses 220 cycles after the load edge; busy returns to 0.
REQ-030 Back-to-back: load 0xA5 in IDLE, then load 0x0F 5 cycles later -> ready=0 until cycle 220; the second start bit begins at cycle 220 with no idle gap; two done pulses, at 220 and 440.
REQ-031 Overrun: while ready=0, pulse load with 0xFF -> ignored; the second frame still carries 0x0F.
REQ-032 PARITY_ODD=1, BIT_TICKS=4, data 0x00 -> parity bit 1; frame length 44 cycles.
REQ-033 Reset mid-frame: assert rst during data bit 3 -> tx=1 immediately, no done pulse, held byte lost; after release tx stays idle until the next load.
